// File: rtl/item_select_arbiter.sv
// item_select_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one item_selector.
//   One transaction is in flight at a time. The FSM walks
//   IDLE -> ISSUE -> WAIT_RDY -> WAIT_DROP -> IDLE.
//
//   Optional feature: define ITEM_SELECT_ARB_TIMEOUT_EN to add a WAIT_RDY
//   watchdog of TIMEOUT_CYCLES clocks. Without it timeout_err is tied low and
//   no counter exists.
//
// Ports
//   clk, rst               : clock (rising edge) and asynchronous active-high reset
//   req / req_item         : per-requester request (held until ack) and item slice
//   ack / ack_item         : one-hot completion pulse and the captured selected item
//   sel_item_select[_valid]: request towards the item_selector (valid is a 1-cycle pulse)
//   sel_selected_item      : response item from the item_selector
//   sel_selection_ready    : response strobe from the item_selector
//   busy                   : high whenever the FSM is not in IDLE
//   timeout_err            : 1-cycle pulse when the selector never answered
module item_select_arbiter #(
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int NUM_REQ         = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*ITEM_ADDR_WIDTH-1:0] req_item,
  output logic [NUM_REQ-1:0]                 ack,
  output logic [ITEM_ADDR_WIDTH-1:0]         ack_item,
  output logic [ITEM_ADDR_WIDTH-1:0]         sel_item_select,
  output logic                               sel_item_select_valid,
  input  logic [ITEM_ADDR_WIDTH-1:0]         sel_selected_item,
  input  logic                               sel_selection_ready,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam int             PTR_W     = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RDY  = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [PTR_W-1:0]           grant_q, grant_d;
  logic [ITEM_ADDR_WIDTH-1:0] item_q, item_d;
  logic [ITEM_ADDR_WIDTH-1:0] ack_item_q, ack_item_d;
  logic [NUM_REQ-1:0]         ack_q, ack_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;

`ifdef ITEM_SELECT_ARB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  logic                       pick_found_s;
  logic [PTR_W-1:0]           pick_idx_s;
  logic [ITEM_ADDR_WIDTH-1:0] pick_item_s;
  logic [PTR_W:0]             sum_s, cand_s;
  logic [PTR_W:0]             grant_inc_s;
  logic [PTR_W-1:0]           ptr_adv_s;
  logic [NUM_REQ-1:0]         ack_onehot_s;

  // Round-robin pick: first asserted req at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    pick_item_s  = '0;
    sum_s        = '0;
    cand_s       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s  = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      cand_s = (sum_s >= NUM_REQ_W) ? (sum_s - NUM_REQ_W) : sum_s;
      if (!pick_found_s && req[cand_s[PTR_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
    // Constant-index mux keeps the item slice selection free of variable part-selects.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_s == PTR_W'(i)) begin
        pick_item_s = req_item[i*ITEM_ADDR_WIDTH +: ITEM_ADDR_WIDTH];
      end else begin
        pick_item_s = pick_item_s;
      end
    end
  end

  // Pointer moves past the current grant only once the transaction has finished.
  assign grant_inc_s  = {1'b0, grant_q} + {{PTR_W{1'b0}}, 1'b1};
  assign ptr_adv_s    = (grant_inc_s >= NUM_REQ_W) ? '0 : grant_inc_s[PTR_W-1:0];
  assign ack_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

  // Next-state and registered-output decode for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    item_d     = item_q;
    ack_item_d = ack_item_q;
    ack_d      = '0;
    valid_d    = 1'b0;
`ifdef ITEM_SELECT_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // sel_selection_ready is deliberately not looked at here.
        if (pick_found_s) begin
          grant_d = pick_idx_s;
          item_d  = pick_item_s;
          valid_d = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT_RDY;
`ifdef ITEM_SELECT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_RDY: begin
        if (sel_selection_ready) begin
          ack_item_d = sel_selected_item;
          ack_d      = ack_onehot_s;
          ptr_d      = ptr_adv_s;
          state_d    = WAIT_DROP;
`ifdef ITEM_SELECT_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          tmo_d      = 1'b1;
          ack_item_d = '0;
          ptr_d      = ptr_adv_s;
          state_d    = WAIT_DROP;
        end else begin
          cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
`else
        end else begin
          state_d    = WAIT_RDY;
        end
`endif
      end
      WAIT_DROP: begin
        // A sticky ready must fall before another request may be issued.
        if (!sel_selection_ready) begin
          item_d  = '0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_DROP;
        end
      end
      default: begin
        item_d  = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      item_q     <= '0;
      ack_item_q <= '0;
      ack_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ITEM_SELECT_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      item_q     <= item_d;
      ack_item_q <= ack_item_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
`ifdef ITEM_SELECT_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign ack                   = ack_q;
  assign ack_item              = ack_item_q;
  assign sel_item_select       = item_q;
  assign sel_item_select_valid = valid_q;
  assign busy                  = busy_q;
`ifdef ITEM_SELECT_ARB_TIMEOUT_EN
  assign timeout_err           = tmo_q;
`else
  assign timeout_err           = 1'b0;
`endif

endmodule
